// File: rtl/pci_rr_arbiter.sv
// Round-robin PCI central arbiter with a mandatory idle-grant gap and grant timeout.
// Define PCI_ARB_PARK_EN to park the bus on PARK_MASTER when no master is requesting.
module pci_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int TIMEOUT     = 16,
    parameter int PARK_MASTER = 0,
    localparam int OWNER_W    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   pci_clk,
    input  logic                   pci_reset_comb,
    input  logic [NUM_MASTERS-1:0] req_n,
    input  logic                   frame_n,
    input  logic                   irdy_n,
    input  logic                   arbitration_enable,
    output logic [NUM_MASTERS-1:0] gnt_n,
    output logic [OWNER_W-1:0]     owner,
    output logic                   owner_valid,
    output logic                   timeout_pulse
);

    typedef enum logic [1:0] {S_IDLE, S_GRANTED, S_BUSY, S_GAP} state_t;
    typedef struct packed {
        logic               found;
        logic [OWNER_W-1:0] idx;
    } pick_t;

`ifdef PCI_ARB_PARK_EN
    localparam logic PARK_EN = 1'b1;
`else
    localparam logic PARK_EN = 1'b0;
`endif
    localparam logic [7:0]         TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [OWNER_W-1:0] PARK_IDX = OWNER_W'(PARK_MASTER);

    state_t                 state;
    logic [NUM_MASTERS-1:0] req_q;
    logic                   frame_q;
    logic                   irdy_q;
    logic [7:0]             idle_cnt;
    logic                   excl_vld;
    logic [OWNER_W-1:0]     excl_idx;
    logic [NUM_MASTERS-1:0] req_m;
    logic [NUM_MASTERS-1:0] owner_oh;
    logic                   bus_idle;
    logic                   owner_req;
    logic                   others_req;
    pick_t                  win;

    function automatic logic [NUM_MASTERS-1:0] onehot(input logic [OWNER_W-1:0] idx);
        logic [NUM_MASTERS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (idx == OWNER_W'(i)) v[i] = 1'b1;
        return v;
    endfunction

    // Scan upward from last+1 with wrap, so the previous owner is considered last.
    function automatic pick_t pick_next(input logic [NUM_MASTERS-1:0] req,
                                        input logic [OWNER_W-1:0]     last);
        pick_t p;
        int    idx;
        p = '0;
        for (int d = 1; d <= NUM_MASTERS; d++) begin
            idx = int'(last) + d;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (!p.found && req[idx]) begin
                p.found = 1'b1;
                p.idx   = OWNER_W'(idx);
            end
        end
        return p;
    endfunction

    always_comb begin
        bus_idle   = !frame_q && !irdy_q;
        owner_oh   = onehot(owner);
        owner_req  = |(req_q & owner_oh);
        others_req = |(req_q & ~owner_oh);
        req_m      = req_q;
        if (excl_vld) req_m = req_q & ~onehot(excl_idx);
        win        = pick_next(req_m, owner);
    end

    always_ff @(posedge pci_clk or posedge pci_reset_comb) begin
        if (pci_reset_comb) begin
            state         <= S_IDLE;
            req_q         <= '0;
            frame_q       <= 1'b0;
            irdy_q        <= 1'b0;
            gnt_n         <= '1;
            owner         <= '0;
            owner_valid   <= 1'b0;
            timeout_pulse <= 1'b0;
            idle_cnt      <= '0;
            excl_vld      <= 1'b0;
            excl_idx      <= '0;
        end else begin
            req_q         <= ~req_n;
            frame_q       <= ~frame_n;
            irdy_q        <= ~irdy_n;
            timeout_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A parked master may start a cycle without ever requesting.
                    if (owner_valid && frame_q) begin
                        state <= S_BUSY;
                    end else if (owner_valid && !arbitration_enable) begin
                        gnt_n       <= '1;
                        owner_valid <= 1'b0;
                        state       <= S_GAP;
                    end else if (arbitration_enable && win.found) begin
                        if (!owner_valid || win.idx == owner) begin
                            gnt_n       <= ~onehot(win.idx);
                            owner       <= win.idx;
                            owner_valid <= 1'b1;
                            idle_cnt    <= '0;
                            state       <= S_GRANTED;
                        end else begin
                            gnt_n       <= '1;
                            owner_valid <= 1'b0;
                            state       <= S_GAP;
                        end
                    end else if (PARK_EN && arbitration_enable && !owner_valid) begin
                        gnt_n       <= ~onehot(PARK_IDX);
                        owner       <= PARK_IDX;
                        owner_valid <= 1'b1;
                    end
                end
                S_GRANTED: begin
                    if (frame_q) begin
                        state <= S_BUSY;
                    end else if (!arbitration_enable || !owner_req) begin
                        gnt_n       <= '1;
                        owner_valid <= 1'b0;
                        state       <= S_GAP;
                    end else if (bus_idle) begin
                        if (idle_cnt == TO_LAST) begin
                            gnt_n         <= '1;
                            owner_valid   <= 1'b0;
                            timeout_pulse <= 1'b1;
                            excl_vld      <= 1'b1;
                            excl_idx      <= owner;
                            state         <= S_GAP;
                        end else begin
                            idle_cnt <= idle_cnt + 8'd1;
                        end
                    end else begin
                        idle_cnt <= '0;
                    end
                end
                S_BUSY: begin
                    if (!frame_q) begin
                        if (others_req || !owner_req) begin
                            gnt_n       <= '1;
                            owner_valid <= 1'b0;
                            state       <= S_GAP;
                        end else begin
                            idle_cnt <= '0;
                            state    <= S_GRANTED;
                        end
                    end
                end
                S_GAP: begin
                    excl_vld <= 1'b0;
                    if (arbitration_enable && win.found) begin
                        gnt_n       <= ~onehot(win.idx);
                        owner       <= win.idx;
                        owner_valid <= 1'b1;
                        idle_cnt    <= '0;
                        state       <= S_GRANTED;
                    end else if (PARK_EN && arbitration_enable) begin
                        gnt_n       <= ~onehot(PARK_IDX);
                        owner       <= PARK_IDX;
                        owner_valid <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pci_rr_arbiter.sv
// Bench for pci_rr_arbiter: directed vector table, async reset check, and randomized
// traffic compared against a transaction-level reference model.
module tb_pci_rr_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;
    localparam int PM = 0;
`ifdef PCI_ARB_PARK_EN
    localparam bit PARK = 1'b1;
`else
    localparam bit PARK = 1'b0;
`endif

    logic         pci_clk = 1'b0;
    logic         pci_reset_comb;
    logic [N-1:0] req_n;
    logic         frame_n;
    logic         irdy_n;
    logic         arbitration_enable;
    logic [N-1:0] gnt_n;
    logic [1:0]   owner;
    logic         owner_valid;
    logic         timeout_pulse;

    always #5 pci_clk = ~pci_clk;

    pci_rr_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TO), .PARK_MASTER(PM)) dut (
        .pci_clk            (pci_clk),
        .pci_reset_comb     (pci_reset_comb),
        .req_n              (req_n),
        .frame_n            (frame_n),
        .irdy_n             (irdy_n),
        .arbitration_enable (arbitration_enable),
        .gnt_n              (gnt_n),
        .owner              (owner),
        .owner_valid        (owner_valid),
        .timeout_pulse      (timeout_pulse)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] outs(input logic [3:0] g, input logic [1:0] o,
                                         input logic ov, input logic tp);
        return {24'd0, g, o, ov, tp};
    endfunction

    // Directed vectors: inputs applied before an edge, outputs expected after it.
    typedef struct {
        logic [3:0] rn;
        logic       fn;
        logic       in;
        logic       en;
        logic [3:0] gnt;
        logic [1:0] own;
        logic       ov;
        logic       tp;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic [3:0] rn, input logic fn, input logic in,
                                input logic en, input logic [3:0] gnt, input logic [1:0] own,
                                input logic ov, input logic tp);
        vec_t v;
        v.rn = rn; v.fn = fn; v.in = in; v.en = en;
        v.gnt = gnt; v.own = own; v.ov = ov; v.tp = tp;
        tbl.push_back(v);
    endfunction

    // Reference model: who holds the grant, whether their transaction started,
    // whether the mandatory gap is in progress, and how long the bus has sat idle.
    int         m_hold;
    int         m_owner;
    bit         m_parked;
    bit         m_started;
    bit         m_gap;
    bit         m_pulse;
    int         m_cnt;
    int         m_skip;
    bit [N-1:0] m_req;
    bit         m_frame;
    bit         m_irdy;

    function automatic int m_pick(input bit [N-1:0] rq, input int from, input int skip);
        for (int d = 1; d <= N; d++) begin
            int c;
            c = (from + d) % N;
            if (rq[c] && c != skip) return c;
        end
        return -1;
    endfunction

    function automatic void m_reset();
        m_hold = -1; m_owner = 0; m_parked = 0; m_started = 0; m_gap = 0;
        m_pulse = 0; m_cnt = 0; m_skip = -1; m_req = '0; m_frame = 0; m_irdy = 0;
    endfunction

    function automatic void m_give(input int w);
        m_hold = w; m_owner = w; m_parked = 0; m_started = 0; m_cnt = 0;
    endfunction

    function automatic void m_park();
        m_hold = PM; m_owner = PM; m_parked = 1; m_started = 0;
    endfunction

    function automatic void m_drop();
        m_hold = -1; m_gap = 1; m_parked = 0; m_started = 0;
    endfunction

    function automatic void m_step(input logic [N-1:0] rn, input logic fn, input logic in,
                                   input logic en);
        int w;
        int h;
        bit idle;
        idle    = !m_frame && !m_irdy;
        m_pulse = 0;
        if (m_gap) begin
            m_gap  = 0;
            w      = m_pick(m_req, m_owner, m_skip);
            m_skip = -1;
            if (en && w >= 0) m_give(w);
            else if (PARK && en) m_park();
            else m_hold = -1;
        end else if (m_hold < 0) begin
            w = m_pick(m_req, m_owner, -1);
            if (en && w >= 0) m_give(w);
            else if (PARK && en) m_park();
        end else if (m_parked) begin
            if (m_frame) begin
                m_parked = 0; m_started = 1;
            end else if (!en) begin
                m_drop();
            end else begin
                w = m_pick(m_req, m_owner, -1);
                if (w == m_hold) m_give(w);
                else if (w >= 0) m_drop();
            end
        end else if (m_started) begin
            if (!m_frame) begin
                if ((m_req & ~(N'(1) << m_hold)) != 0 || !m_req[m_hold]) m_drop();
                else begin m_started = 0; m_cnt = 0; end
            end
        end else begin
            if (m_frame) m_started = 1;
            else if (!en || !m_req[m_hold]) m_drop();
            else if (idle) begin
                if (m_cnt + 1 == TO) begin
                    h = m_hold; m_drop(); m_pulse = 1; m_skip = h;
                end else m_cnt++;
            end else m_cnt = 0;
        end
        m_req = ~rn; m_frame = ~fn; m_irdy = ~in;
    endfunction

    function automatic logic [31:0] m_outs();
        logic [3:0] g;
        g = (m_hold < 0) ? 4'hF : ~(4'b0001 << m_hold);
        return outs(g, 2'(m_owner), m_hold >= 0, m_pulse);
    endfunction

    initial begin
        logic [3:0] prev_gnt;
        logic [3:0] exp_busy;
        int         mode;

        pci_reset_comb = 1'b1;
        req_n = '1; frame_n = 1'b1; irdy_n = 1'b1; arbitration_enable = 1'b1;
        repeat (2) @(posedge pci_clk);
        #1;
        check("reset", outs(gnt_n, owner, owner_valid, timeout_pulse), outs(4'hF, 2'd0, 1'b0, 1'b0));
        pci_reset_comb = 1'b0;

`ifndef PCI_ARB_PARK_EN
        // Master 2 alone: grant two edges after its request, single-phase transaction.
        add(4'b1011, 1, 1, 1, 4'b1111, 2'd0, 0, 0);
        add(4'b1011, 1, 1, 1, 4'b1011, 2'd2, 1, 0);
        add(4'b1011, 0, 0, 1, 4'b1011, 2'd2, 1, 0);
        add(4'b1111, 1, 0, 1, 4'b1011, 2'd2, 1, 0);
        add(4'b1111, 1, 1, 1, 4'b1111, 2'd2, 0, 0);
        add(4'b1111, 1, 1, 1, 4'b1111, 2'd2, 0, 0);
        // Masters 0,1,3 requesting: rotation 3->0->1->3 with a gap between each.
        add(4'b0100, 1, 1, 1, 4'b1111, 2'd2, 0, 0);
        add(4'b0100, 1, 1, 1, 4'b0111, 2'd3, 1, 0);
        add(4'b0100, 0, 0, 1, 4'b0111, 2'd3, 1, 0);
        add(4'b0100, 1, 0, 1, 4'b0111, 2'd3, 1, 0);
        add(4'b0100, 1, 1, 1, 4'b1111, 2'd3, 0, 0);
        add(4'b0100, 1, 1, 1, 4'b1110, 2'd0, 1, 0);
        add(4'b0100, 0, 0, 1, 4'b1110, 2'd0, 1, 0);
        add(4'b0100, 1, 0, 1, 4'b1110, 2'd0, 1, 0);
        add(4'b0100, 1, 1, 1, 4'b1111, 2'd0, 0, 0);
        add(4'b0100, 1, 1, 1, 4'b1101, 2'd1, 1, 0);
        add(4'b0100, 0, 0, 1, 4'b1101, 2'd1, 1, 0);
        add(4'b0100, 1, 0, 1, 4'b1101, 2'd1, 1, 0);
        add(4'b0100, 1, 1, 1, 4'b1111, 2'd1, 0, 0);
        add(4'b0100, 1, 1, 1, 4'b0111, 2'd3, 1, 0);
        // Everyone drops, then master 0 bursts while master 3 requests mid-burst.
        add(4'b1111, 1, 1, 1, 4'b0111, 2'd3, 1, 0);
        add(4'b1111, 1, 1, 1, 4'b1111, 2'd3, 0, 0);
        add(4'b1110, 1, 1, 1, 4'b1111, 2'd3, 0, 0);
        add(4'b1110, 1, 1, 1, 4'b1110, 2'd0, 1, 0);
        add(4'b1110, 0, 0, 1, 4'b1110, 2'd0, 1, 0);
        add(4'b0110, 0, 0, 1, 4'b1110, 2'd0, 1, 0);
        add(4'b0110, 0, 0, 1, 4'b1110, 2'd0, 1, 0);
        add(4'b0110, 1, 0, 1, 4'b1110, 2'd0, 1, 0);
        add(4'b0110, 1, 1, 1, 4'b1111, 2'd0, 0, 0);
        add(4'b0110, 1, 1, 1, 4'b0111, 2'd3, 1, 0);
        // Masters 1 and 2 request; master 1 never starts and times out after 16 idle cycles.
        add(4'b1001, 1, 1, 1, 4'b0111, 2'd3, 1, 0);
        add(4'b1001, 1, 1, 1, 4'b1111, 2'd3, 0, 0);
        add(4'b1001, 1, 1, 1, 4'b1101, 2'd1, 1, 0);
        for (int i = 0; i < TO - 1; i++) add(4'b1001, 1, 1, 1, 4'b1101, 2'd1, 1, 0);
        add(4'b1001, 1, 1, 1, 4'b1111, 2'd1, 0, 1);
        add(4'b1001, 1, 1, 1, 4'b1011, 2'd2, 1, 0);
        // Enable low drops an unstarted grant and blocks new ones.
        add(4'b1001, 1, 1, 0, 4'b1111, 2'd2, 0, 0);
        add(4'b1001, 1, 1, 0, 4'b1111, 2'd2, 0, 0);
        add(4'b1001, 1, 1, 0, 4'b1111, 2'd2, 0, 0);
        add(4'b1001, 1, 1, 1, 4'b1101, 2'd1, 1, 0);
`else
        // Parked on master 0 from the first edge; master 2 then costs one gap cycle.
        add(4'b1111, 1, 1, 1, 4'b1110, 2'd0, 1, 0);
        add(4'b1011, 1, 1, 1, 4'b1110, 2'd0, 1, 0);
        add(4'b1011, 1, 1, 1, 4'b1111, 2'd0, 0, 0);
        add(4'b1011, 1, 1, 1, 4'b1011, 2'd2, 1, 0);
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            req_n = tbl[i].rn; frame_n = tbl[i].fn; irdy_n = tbl[i].in;
            arbitration_enable = tbl[i].en;
            @(posedge pci_clk);
            #1;
            check($sformatf("row%0d", i), outs(gnt_n, owner, owner_valid, timeout_pulse),
                  outs(tbl[i].gnt, tbl[i].own, tbl[i].ov, tbl[i].tp));
        end

        // Current grantee runs a burst; reset mid-cycle must release the grant at once.
        exp_busy = tbl[tbl.size()-1].gnt;
        frame_n = 1'b0; irdy_n = 1'b0;
        repeat (2) @(posedge pci_clk);
        #1;
        check("busy_hold", 32'(gnt_n), 32'(exp_busy));
        #2;
        pci_reset_comb = 1'b1;
        #1;
        check("async_reset", outs(gnt_n, owner, owner_valid, timeout_pulse), outs(4'hF, 2'd0, 1'b0, 1'b0));

        // Randomized traffic against the reference model.
        frame_n = 1'b1; irdy_n = 1'b1; req_n = '1; arbitration_enable = 1'b1;
        @(posedge pci_clk);
        #1;
        m_reset();
        pci_reset_comb = 1'b0;
        prev_gnt = 4'hF;
        mode = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 40 == 0) mode = $urandom_range(0, 3);
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, (mode == 0) ? 47 : 7) == 0) req_n[b] = ~req_n[b];
            if (mode == 0) begin
                frame_n = 1'b1; irdy_n = 1'b1;
            end else begin
                frame_n = ($urandom_range(0, 9) < 4) ? 1'b0 : 1'b1;
                irdy_n  = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 23) == 0) arbitration_enable = ~arbitration_enable;
            m_step(req_n, frame_n, irdy_n, arbitration_enable);
            @(posedge pci_clk);
            #1;
            check($sformatf("rand%0d", c), outs(gnt_n, owner, owner_valid, timeout_pulse), m_outs());
            check($sformatf("onehot%0d", c), 32'($countones(~gnt_n) <= 1), 32'd1);
            if (prev_gnt != 4'hF && gnt_n != 4'hF)
                check($sformatf("nodirect%0d", c), 32'(gnt_n), 32'(prev_gnt));
            prev_gnt = gnt_n;
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
